// File: rtl/prng_multi_channel.sv
// prng_multi_channel
//   Multi-channel pattern generator driven by a 2W-bit step counter.
//   The counter is split into hi/lo halves. Each sample carries
//   ch[k] = hi + (k+1)*lo (mod 2^W) for k = 0..NCH-1.
//   Samples leave through a valid/ready handshake.
//   Defining PRNG_WRAP_STOP_EN makes the run stop in DONE after the counter wraps.
//   Without it, the counter rolls over and the run continues.
// Ports
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   start, stop   1-cycle control pulses (stop wins when both are high in RUN)
//   load_seed     in IDLE, preloads the counter from seed
//   seed          counter preload value (2W bits)
//   out_ready     downstream accepts the sample when out_valid && out_ready
//   out_valid     out_data/out_step hold a valid sample
//   out_data      channel k occupies [k*W +: W]
//   out_step      counter value that produced out_data
//   busy          state is not IDLE
//   wrap          pulses high when the all-ones step is first presented
module prng_multi_channel #(
    parameter int unsigned W   = 8,
    parameter int unsigned NCH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 load_seed,
    input  logic [2*W-1:0]       seed,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [NCH*W-1:0]     out_data,
    output logic [2*W-1:0]       out_step,
    output logic                 busy,
    output logic                 wrap
);

    localparam int unsigned CW = 2 * W;
    localparam int unsigned DW = NCH * W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [CW-1:0]   out_step_q, out_step_d;
    logic            busy_q, busy_d;
    logic            wrap_q, wrap_d;
    logic            load_c;
    logic            cnt_max_c;
    logic [W-1:0]    hi_c, lo_c;

    assign hi_c      = cnt_q[CW-1:W];
    assign lo_c      = cnt_q[W-1:0];
    assign cnt_max_c = &cnt_q;
    // A new sample is produced when running and the output slot is free or draining.
    assign load_c    = (state_q == ST_RUN) && !stop && (!out_valid_q || out_ready);

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_step_d  = out_step_q;
        wrap_d      = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (load_c) begin
            out_valid_d = 1'b1;
            out_step_d  = cnt_q;
            cnt_d       = cnt_q + CW'(1);
            wrap_d      = cnt_max_c;
            for (int k = 0; k < int'(NCH); k++) begin
                out_data_d[k*W +: W] = hi_c + W'(k + 1) * lo_c;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (load_seed) begin
                    cnt_d = seed;
                end
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
`ifdef PRNG_WRAP_STOP_EN
                end else if (load_c && cnt_max_c) begin
                    state_d = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_step_q  <= '0;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_step_q  <= out_step_d;
            busy_q      <= busy_d;
            wrap_q      <= wrap_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_step  = out_step_q;
    assign busy      = busy_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_prng_multi_channel.sv
// Testbench for prng_multi_channel (W=8, NCH=2).
// A transaction-level model predicts every sample the design should emit.
// A negedge monitor compares each accepted sample against the expected queue.
module tb_prng_multi_channel;

    localparam int unsigned W   = 8;
    localparam int unsigned NCH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, stop, load_seed, out_ready;
    logic [2*W-1:0]    seed;
    logic              out_valid, busy, wrap;
    logic [NCH*W-1:0]  out_data;
    logic [2*W-1:0]    out_step;

    prng_multi_channel #(.W(W), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .load_seed (load_seed),
        .seed      (seed),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_step  (out_step),
        .busy      (busy),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] step;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: 0 = idle, 1 = run, 2 = done
    int   m_state = 0;
    int   m_cnt   = 0;
    bit   m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances alongside the design.
    task automatic cyc(input bit st, input bit sp, input bit ls,
                       input logic [15:0] sd, input bit rdy);
        bit   ld;
        exp_t e;
        int   hi, lo;
        start = st; stop = sp; load_seed = ls; seed = sd; out_ready = rdy;
        ld = (m_state == 1) && !sp && (!m_valid || rdy);
        if (ld) begin
            hi = m_cnt / 256;
            lo = m_cnt % 256;
            e.step       = 16'(m_cnt);
            e.data[7:0]  = 8'((hi + lo) % 256);
            e.data[15:8] = 8'((hi + 2 * lo) % 256);
            q.push_back(e);
        end
        if (ld) m_valid = 1'b1;
        else if (m_valid && rdy) m_valid = 1'b0;
        case (m_state)
            0: begin
                if (ls) m_cnt = int'(sd);
                if (st) m_state = 1;
            end
            1: begin
                if (sp) m_state = 0;
`ifdef PRNG_WRAP_STOP_EN
                else if (ld && m_cnt == 65535) m_state = 2;
`endif
            end
            default: begin
                if (st) begin
                    m_state = 1;
                    m_cnt   = 0;
                end
            end
        endcase
        if (ld) m_cnt = (m_cnt + 1) % 65536;
        @(posedge clk);
        #1;
        chk("busy", 32'(busy), 32'(m_state != 0));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
    endtask

    task automatic idle_n(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, rdy);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"},  32'(out_data),  32'd0);
        chk({tag, "_step"},  32'(out_step),  32'd0);
        chk({tag, "_wrap"},  32'(wrap),      32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    // Monitor: compares accepted samples and checks stall stability and wrap.
    bit          mon_stall = 1'b0;
    bit          mon_first = 1'b1;
    logic [15:0] mon_step;
    logic [15:0] mon_data;

    always @(negedge clk) begin
        if (rst) begin
            mon_stall = 1'b0;
            mon_first = 1'b1;
        end else begin
            if (mon_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_step",  32'(out_step),  32'(mon_step));
                chk("stall_data",  32'(out_data),  32'(mon_data));
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: step 0x%0h with nothing expected at %0t",
                             out_step, $time);
                end else begin
                    if (mon_first)
                        chk("wrap", 32'(wrap), 32'(q[0].step == 16'hFFFF));
                    else
                        chk("wrap_hold", 32'(wrap), 32'd0);
                    if (out_ready) begin
                        chk("step", 32'(out_step), 32'(q[0].step));
                        chk("data", 32'(out_data), 32'(q[0].data));
                        void'(q.pop_front());
                    end
                end
            end
            mon_stall = out_valid && !out_ready;
            mon_step  = out_step;
            mon_data  = out_data;
            mon_first = !out_valid || out_ready;
        end
    end

    initial begin
        rst = 1'b1;
        start = 1'b0; stop = 1'b0; load_seed = 1'b0; seed = '0; out_ready = 1'b0;
        #3;
        check_zero_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Free run from zero, past step 257.
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        idle_n(300, 1'b1);

        // Backpressure for 5 clocks, then release.
        idle_n(5, 1'b0);
        idle_n(10, 1'b1);

        // load_seed while running is ignored.
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, 16'hABCD, 1'b1);

        // Stop with a stalled pending sample.
        idle_n(1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        idle_n(2, 1'b0);
        idle_n(3, 1'b1);

        // Start and stop together in RUN: stop wins.
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        idle_n(3, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
        idle_n(3, 1'b1);

        // Seed near the top and cross the wrap point.
        cyc(1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b1);
        idle_n(8, 1'b1);
`ifdef PRNG_WRAP_STOP_EN
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        idle_n(5, 1'b1);
`endif
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        idle_n(3, 1'b1);

        // Wrap with the all-ones sample stalled on arrival.
        cyc(1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b1);
        idle_n(1, 1'b1);
        idle_n(3, 1'b0);
        idle_n(6, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

        // Randomised control and backpressure.
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 12) == 0, ($urandom % 40) == 0, ($urandom % 6) == 0,
                16'($urandom), ($urandom % 4) != 0);
        end

        // Asynchronous reset mid-run.
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        idle_n(4, 1'b1);
        start = 1'b0; stop = 1'b0; load_seed = 1'b0; out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        q.delete();
        m_state = 0;
        m_cnt   = 0;
        m_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        idle_n(20, 1'b1);

        // Drain and confirm nothing is left outstanding.
        cyc(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        idle_n(4, 1'b1);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
